// File: rtl/matmul_sequencer.sv
// Sequencer that computes C = A x B over the shared three-matrix register file,
// one C cell at a time in row-major order, using a single multiply-accumulate.
module matmul_sequencer #(
  parameter int size          = 4,
  parameter int address_width = $clog2(size*size),
  parameter int cell_width    = 32,
  parameter int width         = cell_width*size
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_start,
  output logic                     out_busy,
  output logic                     out_done,
  output logic [address_width-1:0] out_rf_address,
  output logic [width-1:0]         out_rf_data,
  output logic [1:0]               out_rf_type,
  output logic [1:0]               out_rf_select,
  output logic                     out_rf_read_en,
  output logic                     out_rf_write_en,
  input  logic [width-1:0]         in_rf_data
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [IDX_W-1:0]         LAST   = IDX_W'(size - 1);
  localparam logic [address_width-1:0] SIZE_A = address_width'(size);

  localparam logic [1:0] TYPE_CELL = 2'b00;
  localparam logic [1:0] TYPE_ROW  = 2'b01;
  localparam logic [1:0] TYPE_COL  = 2'b10;
  localparam logic [1:0] SEL_A     = 2'b00;
  localparam logic [1:0] SEL_B     = 2'b01;
  localparam logic [1:0] SEL_C     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ROW,
    S_RD_COL,
    S_CAP_COL,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [IDX_W-1:0]        r_i;
  logic [IDX_W-1:0]        r_j;
  logic [IDX_W-1:0]        r_k;
  logic [cell_width-1:0]   r_acc;
  logic [width-1:0]        r_rowBuf;
  logic [width-1:0]        r_colBuf;

  logic [address_width-1:0] w_rowAddr;
  logic [address_width-1:0] w_cellAddr;
  logic [cell_width-1:0]    w_rowElem;
  logic [cell_width-1:0]    w_colElem;
  logic [cell_width-1:0]    w_product;
  logic                     w_lastCell;

  assign w_rowAddr  = address_width'(r_i) * SIZE_A;
  assign w_cellAddr = w_rowAddr + address_width'(r_j);
  assign w_rowElem  = r_rowBuf[int'(r_k)*cell_width +: cell_width];
  assign w_colElem  = r_colBuf[int'(r_k)*cell_width +: cell_width];
  assign w_product  = w_rowElem * w_colElem;
  assign w_lastCell = (r_i == LAST) && (r_j == LAST);

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_rowBuf <= '0;
      r_colBuf <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_i <= '0;
            r_j <= '0;
          end
        end
        // Read data arrives one cycle after its request, so each buffer is
        // captured in the state following its read.
        S_RD_COL:  r_rowBuf <= in_rf_data;
        S_CAP_COL: begin
          r_colBuf <= in_rf_data;
          r_acc    <= '0;
          r_k      <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_product;
          if (r_k != LAST) r_k <= r_k + IDX_W'(1);
        end
        S_WRITE: begin
          if (r_j != LAST) begin
            r_j <= r_j + IDX_W'(1);
          end else if (r_i != LAST) begin
            r_j <= '0;
            r_i <= r_i + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState     = r_state;
    out_busy        = (r_state != S_IDLE);
    out_done        = 1'b0;
    out_rf_address  = '0;
    out_rf_data     = '0;
    out_rf_type     = TYPE_CELL;
    out_rf_select   = SEL_A;
    out_rf_read_en  = 1'b0;
    out_rf_write_en = 1'b0;
    case (r_state)
      S_IDLE:    if (in_start) w_nextState = S_RD_ROW;
      S_RD_ROW: begin
        out_rf_read_en = 1'b1;
        out_rf_type    = TYPE_ROW;
        out_rf_select  = SEL_A;
        out_rf_address = w_rowAddr;
        w_nextState    = S_RD_COL;
      end
      S_RD_COL: begin
        out_rf_read_en = 1'b1;
        out_rf_type    = TYPE_COL;
        out_rf_select  = SEL_B;
        out_rf_address = address_width'(r_j);
        w_nextState    = S_CAP_COL;
      end
      S_CAP_COL: w_nextState = S_MAC;
      S_MAC:     if (r_k == LAST) w_nextState = S_WRITE;
      S_WRITE: begin
        out_rf_write_en = 1'b1;
        out_rf_type     = TYPE_CELL;
        out_rf_select   = SEL_C;
        out_rf_address  = w_cellAddr;
        out_rf_data     = width'(r_acc);
        w_nextState     = w_lastCell ? S_DONE : S_RD_ROW;
      end
      S_DONE: begin
        out_done    = 1'b1;
        w_nextState = S_IDLE;
      end
      default:   w_nextState = S_IDLE;
    endcase
    // A write coinciding with reset must not reach the register file.
    if (in_reset) out_rf_write_en = 1'b0;
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (size=2) driving a behavioural register file
// with registered read data; expected products are hand-computed constants.
module tb_matmul_sequencer;

  localparam int SIZE = 2;
  localparam int CW   = 32;
  localparam int AW   = $clog2(SIZE*SIZE);
  localparam int W    = CW*SIZE;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rfAddr;
  logic [W-1:0]  rfWdata;
  logic [1:0]    rfType;
  logic [1:0]    rfSel;
  logic          rfRe;
  logic          rfWe;
  logic [W-1:0]  rfRdata;

  logic          tbWe;
  logic [1:0]    tbSel;
  logic [AW-1:0] tbAddr;
  logic [CW-1:0] tbData;

  logic [CW-1:0] mem [0:2][0:SIZE*SIZE-1];

  logic [5:0]    writeLog [$];
  int            bothCnt = 0;
  int            doneCnt = 0;

  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  matmul_sequencer #(
    .size(SIZE), .address_width(AW), .cell_width(CW), .width(W)
  ) dut (
    .in_clk(clk),
    .in_reset(reset),
    .in_start(start),
    .out_busy(busy),
    .out_done(done),
    .out_rf_address(rfAddr),
    .out_rf_data(rfWdata),
    .out_rf_type(rfType),
    .out_rf_select(rfSel),
    .out_rf_read_en(rfRe),
    .out_rf_write_en(rfWe),
    .in_rf_data(rfRdata)
  );

  // Behavioural register file: cell writes, row/column/cell reads, one-cycle read latency.
  always @(posedge clk) begin
    if (tbWe) begin
      mem[tbSel][tbAddr] <= tbData;
    end else if (rfWe && rfType == 2'b00 && rfSel != 2'b11) begin
      mem[rfSel][rfAddr] <= rfWdata[CW-1:0];
    end
    if (rfRe && rfSel != 2'b11) begin
      for (int e = 0; e < SIZE; e++) begin
        int rowBase;
        int colIdx;
        rowBase = (int'(rfAddr) / SIZE) * SIZE;
        colIdx  = int'(rfAddr) % SIZE;
        if (rfType == 2'b01)
          rfRdata[e*CW +: CW] <= mem[rfSel][rowBase + e];
        else if (rfType == 2'b10)
          rfRdata[e*CW +: CW] <= mem[rfSel][e*SIZE + colIdx];
        else
          rfRdata[e*CW +: CW] <= (e == 0) ? mem[rfSel][rfAddr] : '0;
      end
    end
  end

  // Bus monitor: logs every write and counts protocol events.
  always @(negedge clk) begin
    if (rfWe) writeLog.push_back({rfSel, rfType, rfAddr});
    if (rfRe && rfWe) bothCnt++;
    if (done) doneCnt++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic writeCell(input logic [1:0] sel, input int addr, input logic [CW-1:0] data);
    @(negedge clk);
    tbWe   = 1'b1;
    tbSel  = sel;
    tbAddr = AW'(addr);
    tbData = data;
    @(negedge clk);
    tbWe   = 1'b0;
  endtask

  task automatic loadMatrix(input logic [1:0] sel, input logic [CW-1:0] m0, input logic [CW-1:0] m1,
                            input logic [CW-1:0] m2, input logic [CW-1:0] m3);
    writeCell(sel, 0, m0);
    writeCell(sel, 1, m1);
    writeCell(sel, 2, m2);
    writeCell(sel, 3, m3);
  endtask

  task automatic checkMatrix(input string tag, input int sel, input logic [CW-1:0] m0, input logic [CW-1:0] m1,
                             input logic [CW-1:0] m2, input logic [CW-1:0] m3);
    checkOutput({tag, "[0][0]"}, mem[sel][0], m0);
    checkOutput({tag, "[0][1]"}, mem[sel][1], m1);
    checkOutput({tag, "[1][0]"}, mem[sel][2], m2);
    checkOutput({tag, "[1][1]"}, mem[sel][3], m3);
  endtask

  // Accepts a start, then counts cycles (bounded) until the done pulse.
  task automatic applyStimulus(input bit holdStart, output int cycles, output int gaps);
    cycles = 0;
    gaps   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      if (busy !== 1'b1) gaps++;
      if (done === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  initial begin
    int cycles;
    int gaps;
    int wr0;
    int done0;
    int both0;
    int secondCycles;

    reset = 1'b1;
    start = 1'b0;
    tbWe  = 1'b0;
    tbSel = 2'b00;
    tbAddr = '0;
    tbData = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {busy, done, rfRe, rfWe, rfType, rfSel, rfAddr, rfWdata}, '0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);

    // Basic multiply, latency and bus protocol.
    loadMatrix(2'b00, 1, 2, 3, 4);
    loadMatrix(2'b01, 5, 6, 7, 8);
    loadMatrix(2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    wr0 = writeLog.size(); done0 = doneCnt; both0 = bothCnt;
    applyStimulus(1'b0, cycles, gaps);
    repeat (3) @(negedge clk);
    checkMatrix("basic_C", 2, 19, 22, 43, 50);
    checkOutput("basic_cycles", cycles, 25);
    checkOutput("basic_busy_gaps", gaps, 0);
    checkOutput("basic_done_count", doneCnt - done0, 1);
    checkOutput("basic_write_count", writeLog.size() - wr0, 4);
    for (int w = 0; w < 4; w++) begin
      if (writeLog.size() > wr0 + w)
        checkOutput("basic_write_attr", writeLog[wr0 + w], {2'b10, 2'b00, AW'(w)});
    end
    checkOutput("basic_both_en", bothCnt - both0, 0);

    // Truncating arithmetic.
    loadMatrix(2'b00, 32'h10000, 0, 0, 0);
    loadMatrix(2'b01, 32'h10000, 0, 0, 0);
    loadMatrix(2'b10, 32'h55, 32'h55, 32'h55, 32'h55);
    applyStimulus(1'b0, cycles, gaps);
    repeat (3) @(negedge clk);
    checkMatrix("wrap_C", 2, 0, 0, 0, 0);
    loadMatrix(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    loadMatrix(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(1'b0, cycles, gaps);
    repeat (3) @(negedge clk);
    checkMatrix("ones_C", 2, 2, 2, 2, 2);

    // Start held high: no mid-run restart; next run begins right after DONE.
    loadMatrix(2'b00, 1, 2, 3, 4);
    loadMatrix(2'b01, 5, 6, 7, 8);
    loadMatrix(2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    wr0 = writeLog.size(); done0 = doneCnt;
    applyStimulus(1'b1, cycles, gaps);
    checkOutput("hold_cycles", cycles, 25);
    checkOutput("hold_busy_gaps", gaps, 0);
    @(negedge clk);
    checkOutput("hold_idle_after_done", busy, 1'b0);
    @(negedge clk);
    checkOutput("hold_restart_rdrow", {busy, rfRe, rfType, rfSel}, {1'b1, 1'b1, 2'b01, 2'b00});
    start = 1'b0;
    secondCycles = 0;
    for (int n = 2; n <= 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        secondCycles = n;
        break;
      end
    end
    checkOutput("hold_second_cycles", secondCycles, 25);
    repeat (3) @(negedge clk);
    checkOutput("hold_done_count", doneCnt - done0, 2);
    checkOutput("hold_write_count", writeLog.size() - wr0, 8);
    checkMatrix("hold_C", 2, 19, 22, 43, 50);

    // Reset during MAC of cell (0,1).
    loadMatrix(2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_outputs", {busy, done, rfRe, rfWe, rfType, rfSel, rfAddr, rfWdata}, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_C00", mem[2][0], 19);
    checkOutput("abort_C01_kept", mem[2][1], 32'hDEADBEEF);
    applyStimulus(1'b0, cycles, gaps);
    repeat (3) @(negedge clk);
    checkOutput("abort_rerun_cycles", cycles, 25);
    checkMatrix("abort_rerun_C", 2, 19, 22, 43, 50);

    // Identity times B, operands untouched.
    loadMatrix(2'b00, 1, 0, 0, 1);
    loadMatrix(2'b01, 9, 8, 7, 6);
    loadMatrix(2'b10, 0, 0, 0, 0);
    applyStimulus(1'b0, cycles, gaps);
    repeat (3) @(negedge clk);
    checkMatrix("ident_C", 2, 9, 8, 7, 6);
    checkMatrix("ident_A", 0, 1, 0, 0, 1);
    checkMatrix("ident_B", 1, 9, 8, 7, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
